chk_arb: RTL and testbench
==========================

CHK_ARB -- requirements
Module: chk_arb

Interface
REQ-001 Parameter REQS, default 8: number of checker requesters, legal range 2..256.
REQ-002 Parameter CNT_W, default 16: width of the report and error counters.
REQ-003 Parameter ID_W, default $clog2(REQS): width of the granted-index output.
REQ-004 chk_arb_clk_ip  input  1: single clock; all state is updated on its rising edge.
REQ-005 chk_arb_rst_n_ip  input  1: reset, synchronous and active-low.
REQ-006 chk_arb_req_ip  input  REQS: bit i high means requester i has a report pending.
REQ-007 chk_arb_err_ip  input  REQS: bit i qualifies requester i's report (1 = error, 0 = information).
REQ-008 chk_arb_limit_ip  input  CNT_W: error count that ends simulation; 0 disables the limit.
REQ-009 chk_arb_rdy_ip  input  1: downstream reporter accepts the output report this cycle.
REQ-010 chk_arb_gnt_op  output  REQS: one-hot or zero; requester whose report is captured at this edge (combinational).
REQ-011 chk_arb_vld_op  output  1: output report register holds a valid report.
REQ-012 chk_arb_id_op  output  ID_W: index of the requester held in the output register.
REQ-013 chk_arb_iserr_op  output  1: error qualifier of the held report.
REQ-014 chk_arb_rpt_cnt_op  output  CNT_W: total reports captured, saturating.
REQ-015 chk_arb_err_cnt_op  output  CNT_W: error reports captured, saturating.
REQ-016 chk_arb_finish_op  output  1: sticky end-of-simulation request.

Function
REQ-017 Output stage is a one-entry register with two states: EMPTY (vld=0) and HOLD (vld=1).
REQ-018 Capture is allowed in a cycle when (EMPTY, or HOLD with rdy=1) and finish=0; otherwise gnt is all-zero.
REQ-019 When capture is allowed and any req bit is set, exactly one gnt bit is asserted, chosen by round-robin starting from pointer P and wrapping at REQS-1 to 0.
REQ-020 On a grant to index i, P becomes (i+1) mod REQS at the edge; with no grant, P is unchanged.
REQ-021 The granted request is captured at that edge: vld=1, id=i, iserr=err[i] from the next cycle (latency 1 cycle).
REQ-022 Sustained throughput is one report per cycle when rdy is held high.
REQ-023 HOLD with rdy=0: vld, id and iserr stay stable.
REQ-024 HOLD with rdy=1 and no grant: the state goes to EMPTY at the edge.
REQ-025 HOLD with rdy=1 and a grant in the same cycle: the state stays HOLD with the new contents (drain and refill together).
REQ-026 Requesters hold req until they see their gnt bit; req dropped without gnt is not an error, and nothing is captured for it.
REQ-027 On each capture, rpt_cnt increments by 1; err_cnt increments by 1 if err[i]=1; both saturate at 2^CNT_W-1 and never wrap.
REQ-028 finish sets at the edge where limit!=0 and the post-increment err_cnt>=limit; it stays set until reset.
REQ-029 A limit change to a value <= the current err_cnt (and !=0) sets finish at the next edge.
REQ-030 After finish, no new grants are issued; a held report still drains normally via rdy.

Reset
REQ-031 While chk_arb_rst_n_ip is low at a rising edge, the next state is: EMPTY, P=0, vld=0, id=0, iserr=0, rpt_cnt=0, err_cnt=0, finish=0.
REQ-032 gnt is all-zero during any cycle in which chk_arb_rst_n_ip is low.
REQ-033 Reset asserted in HOLD discards the held report without requiring rdy; it is not counted again.

Verification
REQ-034 Reset: drive rst_n=0 for 1 edge with req=all-ones -> all outputs 0 and gnt=0 in that cycle and the next.
REQ-035 Fairness: REQS=4, req=4'b1111 constant, rdy=1 -> gnt 0001,0010,0100,1000,0001; id 0,1,2,3 one cycle later; rpt_cnt=5 after 5 grants.
REQ-036 Backpressure: vld=1, id=2, rdy=0 for 3 cycles with req=4'b0011 -> gnt=0 and id stable; rdy=1 -> same-cycle drain plus grant to the next index after P.
REQ-037 Limit: limit=3, req=all, err=all, rdy=1 -> finish rises at the edge capturing the 3rd error; gnt=0 thereafter; err_cnt=3; last report drains.
REQ-038 Saturation: CNT_W=4, limit=0, 20 information reports -> rpt_cnt=15, err_cnt=0, finish=0.
REQ-039 Mid-operation reset: in HOLD with rdy=0 and err_cnt=5, pulse rst_n low for 1 edge -> vld=0, err_cnt=0, P=0; first grant after release goes to the lowest set req bit.

Source files
------------

// File: rtl/chk_arb_if.sv
// Checker-arbiter bus: requester vectors in, one held report plus counters out.
// Carries no state of its own; timing is set entirely by the arbiter.
// Downstream backpressure travels on chk_arb_rdy_ip.
interface chk_arb_if #(
  parameter int REQS  = 8,
  parameter int CNT_W = 16,
  parameter int ID_W  = $clog2(REQS)
);
  logic [REQS-1:0]  chk_arb_req_ip;
  logic [REQS-1:0]  chk_arb_err_ip;
  logic [CNT_W-1:0] chk_arb_limit_ip;
  logic             chk_arb_rdy_ip;
  logic [REQS-1:0]  chk_arb_gnt_op;
  logic             chk_arb_vld_op;
  logic [ID_W-1:0]  chk_arb_id_op;
  logic             chk_arb_iserr_op;
  logic [CNT_W-1:0] chk_arb_rpt_cnt_op;
  logic [CNT_W-1:0] chk_arb_err_cnt_op;
  logic             chk_arb_finish_op;

  // Requester/reporter side drives requests and readiness.
  modport master (
    output chk_arb_req_ip, chk_arb_err_ip, chk_arb_limit_ip, chk_arb_rdy_ip,
    input  chk_arb_gnt_op, chk_arb_vld_op, chk_arb_id_op, chk_arb_iserr_op,
    input  chk_arb_rpt_cnt_op, chk_arb_err_cnt_op, chk_arb_finish_op
  );

  // Arbiter side.
  modport slave (
    input  chk_arb_req_ip, chk_arb_err_ip, chk_arb_limit_ip, chk_arb_rdy_ip,
    output chk_arb_gnt_op, chk_arb_vld_op, chk_arb_id_op, chk_arb_iserr_op,
    output chk_arb_rpt_cnt_op, chk_arb_err_cnt_op, chk_arb_finish_op
  );
endinterface

// File: rtl/chk_arb.sv
// Round-robin arbiter collecting checker reports into a one-entry output register with counters.
// Latency: 1 cycle from grant to vld/id/iserr; one report per cycle with rdy held high.
// Backpressure: rdy=0 in HOLD freezes the held report and blocks all grants.
module chk_arb #(
  parameter int REQS  = 8,
  parameter int CNT_W = 16,
  parameter int ID_W  = $clog2(REQS)
) (
  input  logic     chk_arb_clk_ip,
  input  logic     chk_arb_rst_n_ip,
  chk_arb_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  id_q;
  logic             iserr_q;
  logic [CNT_W-1:0] rpt_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             finish_q;

  logic             cap_ok;
  logic             gnt_any;
  logic [ID_W-1:0]  gnt_idx;
  logic             cap;
  logic             cap_err;
  logic [REQS-1:0]  gnt;
  logic [CNT_W-1:0] rpt_cnt_nxt;
  logic [CNT_W-1:0] err_cnt_nxt;
  logic             finish_nxt;
  logic [ID_W-1:0]  ptr_nxt;

  // Round-robin search: first set request at or after the pointer, wrapping at REQS-1.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < REQS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= REQS) idx = idx - REQS;
      if (!gnt_any && bus.chk_arb_req_ip[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end

  // Capture is only possible when the output slot frees up this cycle and the run
  // has not been ended; reset is folded in so gnt is quiet while rst_n is low.
  assign cap_ok  = chk_arb_rst_n_ip && !finish_q && ((state_q == EMPTY) || bus.chk_arb_rdy_ip);
  assign cap     = cap_ok && gnt_any;
  assign cap_err = bus.chk_arb_err_ip[gnt_idx];
  assign gnt     = cap ? ({{(REQS-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  // Counter, finish and pointer next-state; counters saturate instead of wrapping.
  // finish compares against the post-increment error count, so a lowered limit
  // also trips it on the next edge even without a capture.
  always_comb begin
    rpt_cnt_nxt = rpt_cnt_q;
    err_cnt_nxt = err_cnt_q;
    ptr_nxt     = ptr_q;
    if (cap) begin
      if (rpt_cnt_q != '1) rpt_cnt_nxt = rpt_cnt_q + 1'b1;
      if (cap_err && (err_cnt_q != '1)) err_cnt_nxt = err_cnt_q + 1'b1;
      ptr_nxt = (int'(gnt_idx) == REQS - 1) ? '0 : gnt_idx + 1'b1;
    end
    finish_nxt = finish_q ||
                 ((bus.chk_arb_limit_ip != '0) && (err_cnt_nxt >= bus.chk_arb_limit_ip));
  end

  // Output-stage FSM plus all registered state; reset drops any held report.
  always_ff @(posedge chk_arb_clk_ip) begin
    if (!chk_arb_rst_n_ip) begin
      state_q   <= EMPTY;
      ptr_q     <= '0;
      id_q      <= '0;
      iserr_q   <= 1'b0;
      rpt_cnt_q <= '0;
      err_cnt_q <= '0;
      finish_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_nxt;
      rpt_cnt_q <= rpt_cnt_nxt;
      err_cnt_q <= err_cnt_nxt;
      finish_q  <= finish_nxt;
      case (state_q)
        EMPTY: begin
          if (cap) begin
            state_q <= HOLD;
            id_q    <= gnt_idx;
            iserr_q <= cap_err;
          end
        end
        HOLD: begin
          if (cap) begin
            id_q    <= gnt_idx;
            iserr_q <= cap_err;
          end else if (bus.chk_arb_rdy_ip) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.chk_arb_gnt_op     = gnt;
  assign bus.chk_arb_vld_op     = (state_q == HOLD);
  assign bus.chk_arb_id_op      = id_q;
  assign bus.chk_arb_iserr_op   = iserr_q;
  assign bus.chk_arb_rpt_cnt_op = rpt_cnt_q;
  assign bus.chk_arb_err_cnt_op = err_cnt_q;
  assign bus.chk_arb_finish_op  = finish_q;

endmodule

// File: tb/tb_chk_arb.sv
// Directed bench for chk_arb: reset, fairness, backpressure, mid-run reset, limit, saturation.
// Output reports are scoreboarded; stimulus pushes expected (id, iserr) pairs.
// Inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_chk_arb;

  logic clk = 1'b0;
  logic a_rst_n;
  logic b_rst_n;

  always #5 clk = ~clk;

  chk_arb_if #(.REQS(4), .CNT_W(16), .ID_W(2)) a_if ();
  chk_arb_if #(.REQS(4), .CNT_W(4),  .ID_W(2)) b_if ();

  chk_arb #(.REQS(4), .CNT_W(16), .ID_W(2)) u_dut_a (
    .chk_arb_clk_ip   (clk),
    .chk_arb_rst_n_ip (a_rst_n),
    .bus              (a_if.slave)
  );

  chk_arb #(.REQS(4), .CNT_W(4), .ID_W(2)) u_dut_b (
    .chk_arb_clk_ip   (clk),
    .chk_arb_rst_n_ip (b_rst_n),
    .bus              (b_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] id;
    logic       iserr;
  } rpt_t;

  rpt_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic iserr);
    rpt_t r;
    r.id    = id;
    r.iserr = iserr;
    exp_q.push_back(r);
  endtask

  // Monitor: every report accepted downstream must match the head of the scoreboard.
  always @(negedge clk) begin
    if (a_rst_n && a_if.chk_arb_vld_op && a_if.chk_arb_rdy_ip) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got id %0d with no report expected at %0t",
                 a_if.chk_arb_id_op, $time);
      end else begin
        rpt_t r;
        r = exp_q.pop_front();
        chk("sb_id", 32'(a_if.chk_arb_id_op), 32'(r.id));
        chk("sb_iserr", 32'(a_if.chk_arb_iserr_op), 32'(r.iserr));
      end
    end
  end

  initial begin
    logic [3:0] fair_gnt [5];
    logic [1:0] fair_id  [5];
    fair_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fair_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    b_rst_n = 1'b0;
    b_if.chk_arb_req_ip   = '0;
    b_if.chk_arb_err_ip   = '0;
    b_if.chk_arb_limit_ip = '0;
    b_if.chk_arb_rdy_ip   = 1'b1;

    // Reset with every request raised.
    a_rst_n = 1'b0;
    a_if.chk_arb_req_ip   = 4'b1111;
    a_if.chk_arb_err_ip   = 4'b0000;
    a_if.chk_arb_limit_ip = '0;
    a_if.chk_arb_rdy_ip   = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 32'(a_if.chk_arb_gnt_op), 32'h0);
    tick();
    a_rst_n = 1'b1;
    a_if.chk_arb_req_ip = 4'b0000;
    @(negedge clk);
    chk("rst_gnt_next", 32'(a_if.chk_arb_gnt_op), 32'h0);
    chk("rst_vld", 32'(a_if.chk_arb_vld_op), 32'h0);
    chk("rst_id", 32'(a_if.chk_arb_id_op), 32'h0);
    chk("rst_iserr", 32'(a_if.chk_arb_iserr_op), 32'h0);
    chk("rst_rpt", 32'(a_if.chk_arb_rpt_cnt_op), 32'h0);
    chk("rst_err", 32'(a_if.chk_arb_err_cnt_op), 32'h0);
    chk("rst_finish", 32'(a_if.chk_arb_finish_op), 32'h0);
    tick();

    // Fairness: all four requesting, rdy high; err pattern 0101.
    a_if.chk_arb_req_ip = 4'b1111;
    a_if.chk_arb_err_ip = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fair_gnt", 32'(a_if.chk_arb_gnt_op), 32'(fair_gnt[i]));
      push(fair_id[i], fair_id[i] == 2'd0 || fair_id[i] == 2'd2);
      tick();
    end
    a_if.chk_arb_req_ip = 4'b0000;
    @(negedge clk);
    chk("fair_rpt", 32'(a_if.chk_arb_rpt_cnt_op), 32'd5);
    chk("fair_err", 32'(a_if.chk_arb_err_cnt_op), 32'd3);
    chk("fair_idle_gnt", 32'(a_if.chk_arb_gnt_op), 32'h0);
    tick();

    // Backpressure: load id 2 (pointer is 1), then stall three cycles.
    a_if.chk_arb_req_ip = 4'b0100;
    a_if.chk_arb_err_ip = 4'b0000;
    @(negedge clk);
    chk("bp_load_gnt", 32'(a_if.chk_arb_gnt_op), 32'b0100);
    push(2'd2, 1'b0);
    tick();
    a_if.chk_arb_req_ip = 4'b0011;
    a_if.chk_arb_rdy_ip = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_gnt", 32'(a_if.chk_arb_gnt_op), 32'h0);
      chk("bp_vld", 32'(a_if.chk_arb_vld_op), 32'h1);
      chk("bp_id", 32'(a_if.chk_arb_id_op), 32'd2);
      tick();
    end
    a_if.chk_arb_rdy_ip = 1'b1;
    @(negedge clk);
    chk("bp_refill_gnt", 32'(a_if.chk_arb_gnt_op), 32'b0001);
    push(2'd0, 1'b0);
    tick();
    a_if.chk_arb_req_ip = 4'b0010;
    @(negedge clk);
    chk("bp_next_gnt", 32'(a_if.chk_arb_gnt_op), 32'b0010);
    push(2'd1, 1'b0);
    tick();
    a_if.chk_arb_req_ip = 4'b0000;
    @(negedge clk);
    chk("bp_rpt", 32'(a_if.chk_arb_rpt_cnt_op), 32'd8);
    tick();

    // Mid-operation reset: reach err_cnt=5 with a report held under rdy=0.
    a_if.chk_arb_req_ip = 4'b0001;
    a_if.chk_arb_err_ip = 4'b0001;
    @(negedge clk);
    chk("mr_gnt0", 32'(a_if.chk_arb_gnt_op), 32'b0001);
    push(2'd0, 1'b1);
    tick();
    a_if.chk_arb_req_ip = 4'b0010;
    a_if.chk_arb_err_ip = 4'b0010;
    @(negedge clk);
    chk("mr_gnt1", 32'(a_if.chk_arb_gnt_op), 32'b0010);
    tick();
    a_if.chk_arb_req_ip = 4'b0000;
    a_if.chk_arb_rdy_ip = 1'b0;
    @(negedge clk);
    chk("mr_err5", 32'(a_if.chk_arb_err_cnt_op), 32'd5);
    chk("mr_vld", 32'(a_if.chk_arb_vld_op), 32'h1);
    chk("mr_id", 32'(a_if.chk_arb_id_op), 32'd1);
    tick();
    a_rst_n = 1'b0;
    a_if.chk_arb_req_ip = 4'b1100;
    @(negedge clk);
    chk("mr_rst_gnt", 32'(a_if.chk_arb_gnt_op), 32'h0);
    tick();
    a_rst_n = 1'b1;
    a_if.chk_arb_req_ip = 4'b1010;
    a_if.chk_arb_err_ip = 4'b0000;
    a_if.chk_arb_rdy_ip = 1'b1;
    @(negedge clk);
    chk("mr_vld0", 32'(a_if.chk_arb_vld_op), 32'h0);
    chk("mr_err0", 32'(a_if.chk_arb_err_cnt_op), 32'd0);
    chk("mr_rpt0", 32'(a_if.chk_arb_rpt_cnt_op), 32'd0);
    chk("mr_first_gnt", 32'(a_if.chk_arb_gnt_op), 32'b0010);
    push(2'd1, 1'b0);
    tick();
    a_if.chk_arb_req_ip = 4'b1000;
    @(negedge clk);
    chk("mr_second_gnt", 32'(a_if.chk_arb_gnt_op), 32'b1000);
    push(2'd3, 1'b0);
    tick();
    a_if.chk_arb_req_ip = 4'b0000;
    @(negedge clk);
    tick();

    // Error limit of 3 with every requester reporting errors.
    a_if.chk_arb_limit_ip = 16'd3;
    a_if.chk_arb_req_ip   = 4'b1111;
    a_if.chk_arb_err_ip   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lim_gnt", 32'(a_if.chk_arb_gnt_op), 32'(4'b0001 << i));
      chk("lim_finish_low", 32'(a_if.chk_arb_finish_op), 32'h0);
      push(2'(i), 1'b1);
      tick();
    end
    @(negedge clk);
    chk("lim_finish", 32'(a_if.chk_arb_finish_op), 32'h1);
    chk("lim_err", 32'(a_if.chk_arb_err_cnt_op), 32'd3);
    chk("lim_gnt_off", 32'(a_if.chk_arb_gnt_op), 32'h0);
    chk("lim_last_vld", 32'(a_if.chk_arb_vld_op), 32'h1);
    tick();
    @(negedge clk);
    chk("lim_drained", 32'(a_if.chk_arb_vld_op), 32'h0);
    chk("lim_gnt_still_off", 32'(a_if.chk_arb_gnt_op), 32'h0);
    chk("lim_finish_sticky", 32'(a_if.chk_arb_finish_op), 32'h1);
    tick();

    // Saturation on the 4-bit counter instance: 20 information reports.
    b_rst_n = 1'b1;
    b_if.chk_arb_req_ip = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      tick();
      @(negedge clk);
      chk("sat_rpt", 32'(b_if.chk_arb_rpt_cnt_op), (i > 15) ? 32'd15 : 32'(i));
    end
    b_if.chk_arb_req_ip = 4'b0000;
    tick();
    @(negedge clk);
    chk("sat_rpt_final", 32'(b_if.chk_arb_rpt_cnt_op), 32'd15);
    chk("sat_err", 32'(b_if.chk_arb_err_cnt_op), 32'd0);
    chk("sat_finish", 32'(b_if.chk_arb_finish_op), 32'h0);

    chk("sb_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
